// File: rtl/wb_master_seq.sv
// Single-outstanding Wishbone pipelined initiator: one local command becomes one
// bus transaction with stall handling, err/ack/rty termination, bounded retry and timeout.
module wb_master_seq #(
  parameter int ADDR_W    = 8,
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // Command handshake: a command transfers on a cycle where cmd_valid_i & cmd_ready_o;
  // cmd_ready_o is only high while idle. rsp_valid_o is a single-cycle pulse with no ready.
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:2] cmd_adr_i,
  input  logic [3:0]        cmd_sel_i,
  input  logic [31:0]       cmd_dat_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_dat_o,
  output logic [1:0]        rsp_status_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:2] wb_adr_o,
  output logic [3:0]        wb_sel_o,
  output logic [31:0]       wb_dat_o,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  input  logic              wb_rty_i,
  input  logic              wb_stall_i,
  input  logic [31:0]       wb_dat_i,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_BACKOFF = 3'd3,
    S_RSP     = 3'd4
  } state_t;

  localparam logic [15:0] TIMEOUT_L   = 16'(TIMEOUT);
  localparam logic [3:0]  MAX_RETRY_L = 4'(MAX_RETRY);

  state_t              state, state_n;
  logic [3:0]          retry_cnt, retry_n;
  logic [15:0]         tmo_cnt, tmo_n;
  logic                cyc_n, stb_n, we_n, ready_n, rsp_valid_n;
  logic [ADDR_W-1:2]   adr_n;
  logic [3:0]          sel_n;
  logic [31:0]         dat_n, rsp_dat_n;
  logic [1:0]          status_n;
  logic                fin;
  logic [1:0]          fin_status;
  logic [31:0]         fin_dat;

  assign dbg_state = state;

  always_comb begin
    state_n     = state;
    retry_n     = retry_cnt;
    tmo_n       = tmo_cnt;
    cyc_n       = wb_cyc_o;
    stb_n       = wb_stb_o;
    we_n        = wb_we_o;
    adr_n       = wb_adr_o;
    sel_n       = wb_sel_o;
    dat_n       = wb_dat_o;
    ready_n     = cmd_ready_o;
    rsp_valid_n = 1'b0;
    rsp_dat_n   = rsp_dat_o;
    status_n    = rsp_status_o;
    fin         = 1'b0;
    fin_status  = 2'b00;
    fin_dat     = 32'd0;

    case (state)
      S_IDLE: begin
        ready_n = 1'b1;
        if (cmd_valid_i && cmd_ready_o) begin
          we_n    = cmd_we_i;
          adr_n   = cmd_adr_i;
          sel_n   = cmd_sel_i;
          dat_n   = cmd_dat_i;
          retry_n = 4'd0;
          tmo_n   = 16'd0;
          cyc_n   = 1'b1;
          stb_n   = 1'b1;
          ready_n = 1'b0;
          state_n = S_REQ;
        end
      end
      S_REQ, S_WAIT: begin
        tmo_n = tmo_cnt + 16'd1;
        // Termination in the timeout cycle takes precedence over the abort.
        if (wb_err_i) begin
          fin        = 1'b1;
          fin_status = 2'b01;
        end else if (wb_ack_i) begin
          fin        = 1'b1;
          fin_status = 2'b00;
          fin_dat    = wb_we_o ? 32'd0 : wb_dat_i;
        end else if (wb_rty_i) begin
          if (retry_cnt < MAX_RETRY_L) begin
            retry_n = retry_cnt + 4'd1;
            cyc_n   = 1'b0;
            stb_n   = 1'b0;
            state_n = S_BACKOFF;
          end else begin
            fin        = 1'b1;
            fin_status = 2'b11;
          end
        end else if (tmo_cnt == TIMEOUT_L) begin
          fin        = 1'b1;
          fin_status = 2'b10;
        end else if (state == S_REQ && !wb_stall_i) begin
          stb_n   = 1'b0;
          state_n = S_WAIT;
        end
        if (fin) begin
          cyc_n       = 1'b0;
          stb_n       = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_dat_n   = fin_dat;
          status_n    = fin_status;
          state_n     = S_RSP;
        end
      end
      S_BACKOFF: begin
        cyc_n   = 1'b1;
        stb_n   = 1'b1;
        tmo_n   = 16'd0;
        state_n = S_REQ;
      end
      S_RSP: begin
        ready_n = 1'b1;
        state_n = S_IDLE;
      end
      default: begin
        cyc_n   = 1'b0;
        stb_n   = 1'b0;
        ready_n = 1'b1;
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      retry_cnt    <= 4'd0;
      tmo_cnt      <= 16'd0;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_adr_o     <= '0;
      wb_sel_o     <= 4'd0;
      wb_dat_o     <= 32'd0;
      cmd_ready_o  <= 1'b1;
      rsp_valid_o  <= 1'b0;
      rsp_dat_o    <= 32'd0;
      rsp_status_o <= 2'b00;
    end else begin
      state        <= state_n;
      retry_cnt    <= retry_n;
      tmo_cnt      <= tmo_n;
      wb_cyc_o     <= cyc_n;
      wb_stb_o     <= stb_n;
      wb_we_o      <= we_n;
      wb_adr_o     <= adr_n;
      wb_sel_o     <= sel_n;
      wb_dat_o     <= dat_n;
      cmd_ready_o  <= ready_n;
      rsp_valid_o  <= rsp_valid_n;
      rsp_dat_o    <= rsp_dat_n;
      rsp_status_o <= status_n;
    end
  end

endmodule

// File: tb/tb_wb_master_seq.sv
// Bench for wb_master_seq: scripted Wishbone slave, response scoreboard fed by an
// attempt-level reference model, directed cases followed by random transactions.
module tb_wb_master_seq;

  localparam int ADDR_W    = 8;
  localparam int TIMEOUT   = 8;
  localparam int MAX_RETRY = 3;
  localparam int W         = 66;
  localparam int PN        = 8;

  localparam int K_ACK    = 0;
  localparam int K_ERR    = 1;
  localparam int K_RTY    = 2;
  localparam int K_ERRACK = 3;
  localparam int K_RTYACK = 4;
  localparam int K_ERRRTY = 5;
  localparam int K_NONE   = 6;

  logic              clk;
  logic              rst_i;
  logic              cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [ADDR_W-1:2] cmd_adr_i;
  logic [3:0]        cmd_sel_i;
  logic [31:0]       cmd_dat_i;
  logic              rsp_valid_o;
  logic [31:0]       rsp_dat_o;
  logic [1:0]        rsp_status_o;
  logic              wb_cyc_o, wb_stb_o, wb_we_o;
  logic [ADDR_W-1:2] wb_adr_o;
  logic [3:0]        wb_sel_o;
  logic [31:0]       wb_dat_o;
  logic              wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i;
  logic [31:0]       wb_dat_i;
  logic [2:0]        dbg_state;

  wb_master_seq #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_sel_i(cmd_sel_i), .cmd_dat_i(cmd_dat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o), .rsp_status_o(rsp_status_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
    .wb_stall_i(wb_stall_i), .wb_dat_i(wb_dat_i), .dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;
  int rsp_seen = 0;
  logic [W-1:0] exp_q[$];

  int          plan_stall[PN];
  int          plan_delay[PN];
  int          plan_kind[PN];
  logic [31:0] plan_rdata;
  logic              cur_we;
  logic [ADDR_W-1:2] cur_adr;
  logic [3:0]        cur_sel;
  logic [31:0]       cur_dat;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #500000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc_cnt);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // ---------------- reference model ----------------
  // Walks the scripted attempts: each attempt lasts until its termination (or the
  // timeout point), a retry adds one idle cycle, and the response follows one cycle later.
  task automatic model(input logic we, output logic [1:0] st, output logic [31:0] d,
                       output int lat);
    int t;
    lat = 0;
    st  = 2'b00;
    d   = 32'd0;
    for (int i = 0; i < PN; i++) begin
      t = plan_stall[i] + plan_delay[i];
      if (plan_kind[i] == K_NONE || t > TIMEOUT) begin
        lat += TIMEOUT + 1;
        st = 2'b10;
        break;
      end
      lat += t + 1;
      if (plan_kind[i] == K_ERR || plan_kind[i] == K_ERRACK || plan_kind[i] == K_ERRRTY) begin
        st = 2'b01;
        break;
      end
      if (plan_kind[i] == K_ACK || plan_kind[i] == K_RTYACK) begin
        st = 2'b00;
        d  = we ? 32'd0 : plan_rdata;
        break;
      end
      if (i < MAX_RETRY) lat += 1;
      else begin
        st = 2'b11;
        break;
      end
    end
    lat += 1;
  endtask

  task automatic clear_plan();
    for (int i = 0; i < PN; i++) begin
      plan_stall[i] = 0;
      plan_delay[i] = 0;
      plan_kind[i]  = K_ACK;
    end
  endtask

  task automatic set_att(input int i, input int s, input int dl, input int k);
    plan_stall[i] = s;
    plan_delay[i] = dl;
    plan_kind[i]  = k;
  endtask

  // ---------------- slave model and bus checks ----------------
  int att = 0;
  int cur = 0;
  int k   = 0;
  bit prev_cyc = 1'b0;

  initial begin
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_stall_i = 1'b0; wb_dat_i = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (cmd_ready_o === 1'b1) att = 0;
      if (wb_cyc_o === 1'b1) begin
        int t, end_idx, kd;
        bit term;
        if (!prev_cyc) begin
          cur = att;
          att++;
          k = 0;
        end else begin
          k++;
        end
        prev_cyc = 1'b1;
        if (cur < PN) begin
          kd = plan_kind[cur];
          t = plan_stall[cur] + plan_delay[cur];
          end_idx = (kd == K_NONE || t > TIMEOUT) ? TIMEOUT : t;
          check("cyc_len", 64'(k <= end_idx), 64'd1);
          check("stb", 64'(wb_stb_o), 64'(k <= plan_stall[cur]));
          check("bus_hold", {wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o},
                {cur_we, cur_adr, cur_sel, cur_dat});
          term       = (kd != K_NONE) && (k == t);
          wb_stall_i = (k < plan_stall[cur]);
          wb_ack_i   = term && (kd == K_ACK || kd == K_ERRACK || kd == K_RTYACK);
          wb_err_i   = term && (kd == K_ERR || kd == K_ERRACK || kd == K_ERRRTY);
          wb_rty_i   = term && (kd == K_RTY || kd == K_RTYACK || kd == K_ERRRTY);
          wb_dat_i   = term ? plan_rdata : $urandom;
        end else begin
          check("attempt_count", 64'(cur), 64'(PN - 1));
        end
      end else begin
        // Stray terminations while the bus is idle, always including the cycle cyc falls.
        wb_ack_i   = prev_cyc || ($urandom_range(0, 3) == 0);
        wb_err_i   = ($urandom_range(0, 5) == 0);
        wb_rty_i   = ($urandom_range(0, 5) == 0);
        wb_stall_i = $urandom_range(0, 1);
        wb_dat_i   = $urandom;
        prev_cyc   = 1'b0;
      end
    end
  end

  // ---------------- response monitor / scoreboard ----------------
  bit after_rsp = 1'b0;
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (after_rsp) begin
        check("ready_after_rsp", 64'(cmd_ready_o), 64'd1);
        after_rsp = 1'b0;
      end
      if (rsp_valid_o === 1'b1) begin
        check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rsp_status", 64'(rsp_status_o), 64'(e[65:64]));
          check("rsp_dat", 64'(rsp_dat_o), 64'(e[63:32]));
          check("rsp_cycle", 64'(cyc_cnt), 64'(e[31:0]));
        end
        rsp_seen++;
        after_rsp = 1'b1;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic we, input logic [ADDR_W-1:2] adr, input logic [3:0] sel,
                       input logic [31:0] dat, input bit expect_rsp, output int a);
    logic [1:0] st;
    logic [31:0] d;
    int lat, bound, target;
    cur_we = we; cur_adr = adr; cur_sel = sel; cur_dat = dat;
    model(we, st, d, lat);
    cmd_valid_i = 1'b1;
    cmd_we_i = we; cmd_adr_i = adr; cmd_sel_i = sel; cmd_dat_i = dat;
    bound = 0;
    while (cmd_ready_o !== 1'b1 && bound < 50) begin
      @(posedge clk); #1;
      bound++;
    end
    check("accept_wait", 64'(cmd_ready_o), 64'd1);
    a = cyc_cnt;
    target = rsp_seen + 1;
    if (expect_rsp) exp_q.push_back({st, d, 32'(a + lat)});
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    cmd_we_i = $urandom_range(0, 1); cmd_adr_i = $urandom; cmd_sel_i = $urandom;
    cmd_dat_i = $urandom;
    if (expect_rsp) begin
      bound = 0;
      while (rsp_seen < target && bound < 100) begin
        @(posedge clk); #1;
        bound++;
      end
      check("rsp_wait", 64'(rsp_seen >= target), 64'd1);
    end
  endtask

  initial begin
    int a;
    rst_i = 1'b1;
    cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = '0; cmd_sel_i = 4'd0; cmd_dat_i = 32'd0;
    cur_we = 1'b0; cur_adr = '0; cur_sel = 4'd0; cur_dat = 32'd0;
    plan_rdata = 32'd0;
    clear_plan();
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    check("rst_ready", 64'(cmd_ready_o), 64'd1);
    check("rst_bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o}, 64'd0);
    check("rst_rsp", {rsp_valid_o, rsp_status_o, rsp_dat_o}, 64'd0);
    @(posedge clk); #1;

    // zero-wait read
    clear_plan(); plan_rdata = 32'hDEADBEEF;
    issue(1'b0, 6'h01, 4'hF, 32'h0, 1'b1, a);
    // stalled write
    clear_plan(); set_att(0, 3, 0, K_ACK); plan_rdata = 32'hA5A5A5A5;
    issue(1'b1, 6'h00, 4'hF, 32'h12345678, 1'b1, a);
    // retry twice then ack
    clear_plan(); set_att(0, 0, 0, K_RTY); set_att(1, 0, 0, K_RTY); plan_rdata = 32'h0BADF00D;
    issue(1'b0, 6'h15, 4'h3, 32'h0, 1'b1, a);
    // retry exhausted
    clear_plan();
    for (int i = 0; i < PN; i++) set_att(i, i % 2, 1, K_RTY);
    issue(1'b1, 6'h2A, 4'h8, 32'hCAFEF00D, 1'b1, a);
    // err together with ack, and rty together with ack
    clear_plan(); set_att(0, 0, 1, K_ERRACK);
    issue(1'b0, 6'h07, 4'hF, 32'h0, 1'b1, a);
    clear_plan(); set_att(0, 1, 0, K_RTYACK); plan_rdata = 32'h13579BDF;
    issue(1'b0, 6'h08, 4'h1, 32'h0, 1'b1, a);
    // timeout, then termination exactly at the timeout point, then one past it
    clear_plan(); set_att(0, 0, 0, K_NONE);
    issue(1'b0, 6'h3F, 4'hF, 32'h0, 1'b1, a);
    clear_plan(); set_att(0, 2, 6, K_ACK); plan_rdata = 32'h89ABCDEF;
    issue(1'b0, 6'h10, 4'hF, 32'h0, 1'b1, a);
    clear_plan(); set_att(0, 2, 7, K_ACK);
    issue(1'b0, 6'h11, 4'hF, 32'h0, 1'b1, a);

    // reset during WAIT: no response, bus released, next command normal
    clear_plan(); set_att(0, 1, 20, K_ACK);
    issue(1'b1, 6'h22, 4'hC, 32'h55AA55AA, 1'b0, a);
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_cyc", 64'(wb_cyc_o), 64'd1);
    check("pre_rst_stb", 64'(wb_stb_o), 64'd0);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    check("midrst_cyc_stb", {wb_cyc_o, wb_stb_o}, 64'd0);
    check("midrst_ready", 64'(cmd_ready_o), 64'd1);
    check("midrst_rsp", 64'(rsp_valid_o), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    clear_plan(); set_att(0, 1, 1, K_ACK); plan_rdata = 32'h2468ACE0;
    issue(1'b0, 6'h22, 4'hF, 32'h0, 1'b1, a);

    // random transactions
    for (int n = 0; n < 40; n++) begin
      int r;
      clear_plan();
      for (int i = 0; i < PN; i++) begin
        r = $urandom_range(0, 11);
        plan_kind[i]  = (r < 5) ? K_ACK : (r == 5) ? K_ERR : (r < 8) ? K_RTY :
                        (r == 8) ? K_ERRACK : (r == 9) ? K_RTYACK : (r == 10) ? K_ERRRTY : K_NONE;
        plan_stall[i] = $urandom_range(0, 3);
        plan_delay[i] = $urandom_range(0, 6);
      end
      plan_rdata = $urandom;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      issue($urandom_range(0, 1), 6'($urandom), 4'($urandom), $urandom, 1'b1, a);
    end

    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_master_seq.md
# wb_master_seq

Single-outstanding pipelined Wishbone initiator that turns local command/response handshakes into Wishbone classic-pipelined cycles on a 32-bit slave bus. It sits between control logic (sequencers, debug bridges, test engines) and generated register banks and submap slaves, including slaves whose stall is `!ack & (cyc & stb)`. It handles stall, ack/err/rty termination, bounded retry on rty, and a transaction timeout.

## Interface
Parameters:
- `ADDR_W`, default 8: byte-address width; the bus carries word address bits `[ADDR_W-1:2]`.
- `TIMEOUT`, default 255: cycles with `wb_cyc_o` high and no termination before abort, range 1..65535.
- `MAX_RETRY`, default 3: re-issues allowed after rty, range 0..15.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset.
- Command channel:
  - `cmd_valid_i` in 1: command present.
  - `cmd_ready_o` out 1: command accepted when `cmd_valid_i & cmd_ready_o`.
  - `cmd_we_i` in 1: 1 = write, 0 = read.
  - `cmd_adr_i` in `[ADDR_W-1:2]`: word address.
  - `cmd_sel_i` in 4: byte selects.
  - `cmd_dat_i` in 32: write data.
- Response channel:
  - `rsp_valid_o` out 1: one-cycle response pulse.
  - `rsp_dat_o` out 32: read data.
  - `rsp_status_o` out 2: 00 ok, 01 err, 10 timeout, 11 retry exhausted.
- Wishbone bus:
  - `wb_cyc_o`, `wb_stb_o`, `wb_we_o` out 1.
  - `wb_adr_o` out `[ADDR_W-1:2]`.
  - `wb_sel_o` out 4.
  - `wb_dat_o` out 32.
  - `wb_ack_i`, `wb_err_i`, `wb_rty_i`, `wb_stall_i` in 1.
  - `wb_dat_i` in 32.

## Operation
- All outputs are registered.
- Reset values: `cmd_ready_o` 1; all other outputs 0.
- FSM states: IDLE, REQ, WAIT, BACKOFF, RSP.
- IDLE:
  - `cmd_ready_o` = 1.
  - On accept, latch we/adr/sel/dat into `wb_*_o`, clear the retry and timeout counters, and go to REQ.
- REQ:
  - `wb_cyc_o` = `wb_stb_o` = 1.
  - If `wb_stall_i` = 0 with no termination, go to WAIT.
- WAIT: `wb_cyc_o` = 1 and `wb_stb_o` = 0.
- Termination:
  - Any of ack/err/rty sampled while `wb_cyc_o` = 1, in REQ or WAIT, ends the attempt regardless of `wb_stall_i`.
  - Priority is err > ack > rty.
- ack: go to RSP with status 00. On a read, capture `wb_dat_i` into `rsp_dat_o`; on a write, set `rsp_dat_o` = 0.
- err: go to RSP with status 01 and `rsp_dat_o` = 0.
- rty with retry count < `MAX_RETRY`:
  - Increment the retry count and go to BACKOFF (cyc = stb = 0 for exactly one cycle).
  - Then go to REQ with the same latched command; the timeout counter is cleared on re-entry.
- rty with retry count = `MAX_RETRY`: go to RSP with status 11 and data 0.
- Timeout:
  - The counter increments every cycle in REQ/WAIT.
  - On the cycle the count reaches `TIMEOUT` with no termination present, go to RSP with status 10 and data 0.
  - A termination in that same cycle wins over timeout.
- RSP:
  - `rsp_valid_o` = 1 for one cycle; cyc and stb are already 0.
  - Next state IDLE.
- Responses cannot be back-pressured.
- `rsp_dat_o` and `rsp_status_o` hold their values until the next RSP.
- `wb_adr_o`, `wb_sel_o`, `wb_we_o`, `wb_dat_o` are stable from REQ entry until the next accept, across retries included.
- Terminations outside REQ/WAIT are ignored.
- `rst_i` mid-transaction: by the next edge, cyc = stb = 0 and state is IDLE; no response is issued for the aborted command.

## Timing
- Cycle A, accept: cycle A+1 has cyc = stb = 1.
- Slave with no stall that acks combinationally in the strobe cycle: termination at A+1, `rsp_valid_o` at A+2, `cmd_ready_o` back at A+3.
- Back-to-back commands: minimum spacing 3 cycles, accept to accept.
- Each stall cycle adds 1 cycle of latency; each cycle waiting for termination adds 1.
- Each retry adds 1 BACKOFF cycle plus the re-issue.
- `wb_stb_o` never stays high after the cycle in which `wb_stall_i` = 0 was sampled.
- `wb_cyc_o` falls on the edge after termination or timeout.
- Timeout abort: `rsp_valid_o` at A + 1 + `TIMEOUT` + 1.

## Test plan
- **Zero-wait read:** read adr 0x1, slave acks in the strobe cycle with `wb_dat_i` = 0xDEADBEEF -> `rsp_valid_o` at A+2, data 0xDEADBEEF, status 00, cyc high for exactly 1 cycle.
- **Stalled write:** write adr 0x0, sel 0xF, dat 0x12345678; stall high 3 cycles, then ack with stall low -> stb high 4 cycles, adr/dat/sel stable throughout, response status 00 with data 0.
- **Retry then success:** slave asserts rty twice, then ack, `MAX_RETRY` = 3 -> two 1-cycle BACKOFF gaps, three strobes with identical address, status 00.
- **Retry exhausted and err:**
  - rty on every attempt with `MAX_RETRY` = 3 -> 4 strobes, status 11.
  - err with ack in the same cycle -> status 01.
- **Timeout:** `TIMEOUT` = 8, slave never terminates -> cyc drops and `rsp_valid_o` is asserted at A+10 with status 10; a late ack after that is ignored.
- **Reset mid-cycle:** assert `rst_i` during WAIT -> next cycle cyc = stb = 0, `cmd_ready_o` = 1, no `rsp_valid_o`; the next command completes normally.
